div_ctrl: RTL and testbench

Sequencer between the EX stage and the shared iterative divider (32-bit, multi-cycle, start/ready handshake, {remainder,quotient} 64-bit result). It accepts one divide/remainder request from EX and asserts the pipeline stall request while the divider runs. It resolves RISC-V special cases without starting the divider, kills in-flight operations on pipeline flush, and watchdogs divider latency.

---
 rtl/div_ctrl.sv | 138 +++++++++++++
 tb/tb_div_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencer between EX and the shared iterative divider: special-case bypass,
// flush kill and latency watchdog.  States: IDLE | BUSY | WAIT_RELEASE | DONE
module div_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   opdata1_i,
  input  logic [XLEN-1:0]   opdata2_i,
  output logic              stallreq_o,
  output logic [XLEN-1:0]   result_o,
  output logic              result_valid_o,
  output logic              timeout_o,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [XLEN-1:0]   div_opdata1_o,
  output logic [XLEN-1:0]   div_opdata2_o,
  input  logic [2*XLEN-1:0] div_result_i,
  input  logic              div_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYC);
  localparam logic [XLEN-1:0] SMIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_RELEASE, DONE} state_t;

  state_t          state_q, state_d;
  logic            rem_q, rem_d;
  logic            signed_q, signed_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            timeout_q, timeout_d;
  logic            annul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= 1'b0;
      signed_q  <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      signed_q  <= signed_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    signed_d  = signed_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    annul     = 1'b0;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          rem_d    = op_i[1];
          signed_d = ~op_i[0];
          opa_d    = opdata1_i;
          opb_d    = opdata2_i;
          cnt_d    = '0;
          // RISC-V defined results for divide-by-zero and signed overflow
          if (opdata2_i == '0) begin
            result_d = op_i[1] ? opdata1_i : '1;
            state_d  = DONE;
          end else if (!op_i[0] && opdata1_i == SMIN && opdata2_i == '1) begin
            result_d = op_i[1] ? '0 : SMIN;
            state_d  = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          annul   = 1'b1;
          state_d = IDLE;
        end else if (div_ready_i) begin
          result_d = rem_q ? div_result_i[2*XLEN-1:XLEN] : div_result_i[XLEN-1:0];
          state_d  = DONE;
        end else if (cnt_inc == CNT_MAX) begin
          annul     = 1'b1;
          timeout_d = 1'b1;
          state_d   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (flush_i) begin
          annul   = 1'b1;
          state_d = IDLE;
        end else begin
          result_d = '0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so every output reads 0 while reset is held, even with req_i high
  assign stallreq_o     = ~rst & (((state_q == IDLE) & req_i & ~flush_i) |
                                  (state_q == BUSY) | (state_q == WAIT_RELEASE));
  assign div_start_o    = (state_q == BUSY);
  assign div_annul_o    = annul;
  assign result_valid_o = (state_q == DONE);
  assign result_o       = result_q;
  assign timeout_o      = timeout_q;
  assign div_signed_o   = signed_q;
  assign div_opdata1_o  = opa_q;
  assign div_opdata2_o  = opb_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the divider is emulated by the stimulus tasks.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        req_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        stallreq_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        timeout_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          r_stall, r_start, r_valid, r_annul;
  logic [31:0] r_res;
  logic        r_sgn;

  div_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .stallreq_o(stallreq_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .timeout_o(timeout_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  // Runs one request from posedge+1; lat = start cycle on which ready rises (0 = never).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] dres);
    bit done = 0;
    op_i = op; opdata1_i = a; opdata2_i = b; req_i = 1'b1;
    r_stall = 0; r_start = 0; r_valid = 0; r_annul = 0; r_res = 32'hDEADBEEF; r_sgn = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (div_start_o && lat != 0 && r_start + 1 >= lat) begin
        div_ready_i = 1'b1; div_result_i = dres;
      end else begin
        div_ready_i = 1'b0; div_result_i = 64'h0;
      end
      #1;
      if (stallreq_o) r_stall++;
      if (div_start_o) begin r_start++; r_sgn = div_signed_o; end
      if (div_annul_o) r_annul++;
      if (result_valid_o) begin r_valid++; r_res = result_o; done = 1; end
      @(posedge clk); #1;
    end
    req_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'h0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (stallreq_o !== 1'b0) $display("FAIL rst_stall got %b exp 0", stallreq_o); else pass_cnt++;
    total_cnt++; if (div_start_o !== 1'b0) $display("FAIL rst_start got %b exp 0", div_start_o); else pass_cnt++;
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", result_valid_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL rst_result got %h exp 0", result_o); else pass_cnt++;
    total_cnt++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout got %b exp 0", timeout_o); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    run_op(2'b01, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    total_cnt++; if (r_stall !== 34) $display("FAIL divu_stall got %0d exp 34", r_stall); else pass_cnt++;
    total_cnt++; if (r_start !== 33) $display("FAIL divu_start got %0d exp 33", r_start); else pass_cnt++;
    total_cnt++; if (r_valid !== 1) $display("FAIL divu_valid got %0d exp 1", r_valid); else pass_cnt++;
    total_cnt++; if (r_res !== 32'd14) $display("FAIL divu_res got %h exp %h", r_res, 32'd14); else pass_cnt++;
    total_cnt++; if (r_annul !== 0) $display("FAIL divu_annul got %0d exp 0", r_annul); else pass_cnt++;
    #1;
    total_cnt++; if (result_o !== 32'd14) $display("FAIL divu_hold got %h exp %h", result_o, 32'd14); else pass_cnt++;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 5, {32'hFFFFFFFF, 32'hFFFFFFFD});
    total_cnt++; if (r_sgn !== 1'b1) $display("FAIL rem_signed got %b exp 1", r_sgn); else pass_cnt++;
    total_cnt++; if (r_res !== 32'hFFFFFFFF) $display("FAIL rem_res got %h exp ffffffff", r_res); else pass_cnt++;
    total_cnt++; if (r_stall !== 6) $display("FAIL rem_stall got %0d exp 6", r_stall); else pass_cnt++;
    run_op(2'b11, 32'd100, 32'd7, 3, {32'd2, 32'd14});
    total_cnt++; if (r_sgn !== 1'b0) $display("FAIL remu_signed got %b exp 0", r_sgn); else pass_cnt++;
    total_cnt++; if (r_res !== 32'd2) $display("FAIL remu_res got %h exp 2", r_res); else pass_cnt++;
  endtask

  task automatic test_special();
    run_op(2'b00, 32'd5, 32'd0, 2, 64'h0);
    total_cnt++; if (r_start !== 0) $display("FAIL div0_start got %0d exp 0", r_start); else pass_cnt++;
    total_cnt++; if (r_stall !== 1) $display("FAIL div0_stall got %0d exp 1", r_stall); else pass_cnt++;
    total_cnt++; if (r_res !== 32'hFFFFFFFF) $display("FAIL div0_res got %h exp ffffffff", r_res); else pass_cnt++;
    run_op(2'b10, 32'd5, 32'd0, 2, 64'h0);
    total_cnt++; if (r_res !== 32'd5) $display("FAIL rem0_res got %h exp 5", r_res); else pass_cnt++;
    total_cnt++; if (r_start !== 0) $display("FAIL rem0_start got %0d exp 0", r_start); else pass_cnt++;
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 2, 64'h0);
    total_cnt++; if (r_start !== 0) $display("FAIL ovf_div_start got %0d exp 0", r_start); else pass_cnt++;
    total_cnt++; if (r_stall !== 1) $display("FAIL ovf_div_stall got %0d exp 1", r_stall); else pass_cnt++;
    total_cnt++; if (r_res !== 32'h80000000) $display("FAIL ovf_div_res got %h exp 80000000", r_res); else pass_cnt++;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 2, 64'h0);
    total_cnt++; if (r_res !== 32'h0) $display("FAIL ovf_rem_res got %h exp 0", r_res); else pass_cnt++;
    // unsigned with the same operands is an ordinary divide
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 2, {32'h80000000, 32'h0});
    total_cnt++; if (r_start !== 2) $display("FAIL ovf_divu_start got %0d exp 2", r_start); else pass_cnt++;
    total_cnt++; if (r_res !== 32'h0) $display("FAIL ovf_divu_res got %h exp 0", r_res); else pass_cnt++;
  endtask

  task automatic test_flush();
    int nv = 0;
    op_i = 2'b01; opdata1_i = 32'd100; opdata2_i = 32'd7; req_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    #1;
    total_cnt++; if (div_annul_o !== 1'b1) $display("FAIL flush_annul got %b exp 1", div_annul_o); else pass_cnt++;
    @(posedge clk); #1;
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    total_cnt++; if (div_annul_o !== 1'b0) $display("FAIL flush_annul_len got %b exp 0", div_annul_o); else pass_cnt++;
    total_cnt++; if (stallreq_o !== 1'b0) $display("FAIL flush_stall got %b exp 0", stallreq_o); else pass_cnt++;
    total_cnt++; if (div_start_o !== 1'b0) $display("FAIL flush_start got %b exp 0", div_start_o); else pass_cnt++;
    if (result_valid_o) nv++;
    @(posedge clk); #1;
    // flush in the same cycle the divider reports ready
    req_i = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1 div_ready_i = 1'b1; div_result_i = {32'd2, 32'd14}; flush_i = 1'b1;
    #1;
    total_cnt++; if (div_annul_o !== 1'b1) $display("FAIL flushrdy_annul got %b exp 1", div_annul_o); else pass_cnt++;
    @(posedge clk); #1;
    flush_i = 1'b0; req_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'h0;
    #1;
    total_cnt++; if (stallreq_o !== 1'b0) $display("FAIL flushrdy_stall got %b exp 0", stallreq_o); else pass_cnt++;
    total_cnt++; if (div_annul_o !== 1'b0) $display("FAIL flushrdy_annul_len got %b exp 0", div_annul_o); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (result_valid_o) nv++;
      @(posedge clk); #1;
    end
    total_cnt++; if (nv !== 0) $display("FAIL flush_no_valid got %0d exp 0", nv); else pass_cnt++;
  endtask

  task automatic test_timeout();
    run_op(2'b00, 32'd77, 32'd3, 0, 64'h0);
    total_cnt++; if (r_start !== 40) $display("FAIL to_start got %0d exp 40", r_start); else pass_cnt++;
    total_cnt++; if (r_annul !== 1) $display("FAIL to_annul got %0d exp 1", r_annul); else pass_cnt++;
    total_cnt++; if (r_stall !== 42) $display("FAIL to_stall got %0d exp 42", r_stall); else pass_cnt++;
    total_cnt++; if (r_valid !== 1) $display("FAIL to_valid got %0d exp 1", r_valid); else pass_cnt++;
    total_cnt++; if (r_res !== 32'h0) $display("FAIL to_res got %h exp 0", r_res); else pass_cnt++;
    total_cnt++; if (timeout_o !== 1'b1) $display("FAIL to_flag got %b exp 1", timeout_o); else pass_cnt++;
    run_op(2'b01, 32'd100, 32'd7, 2, {32'd2, 32'd14});
    total_cnt++; if (r_res !== 32'd14) $display("FAIL to_after_res got %h exp %h", r_res, 32'd14); else pass_cnt++;
    total_cnt++; if (timeout_o !== 1'b1) $display("FAIL to_sticky got %b exp 1", timeout_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    op_i = 2'b00; opdata1_i = 32'd9; opdata2_i = 32'd2; req_i = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++; if (div_start_o !== 1'b1) $display("FAIL mid_start got %b exp 1", div_start_o); else pass_cnt++;
    total_cnt++; if (div_signed_o !== 1'b1) $display("FAIL mid_signed got %b exp 1", div_signed_o); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (div_start_o !== 1'b0) $display("FAIL mrst_start got %b exp 0", div_start_o); else pass_cnt++;
    total_cnt++; if (stallreq_o !== 1'b0) $display("FAIL mrst_stall got %b exp 0", stallreq_o); else pass_cnt++;
    total_cnt++; if (timeout_o !== 1'b0) $display("FAIL mrst_timeout got %b exp 0", timeout_o); else pass_cnt++;
    total_cnt++; if (div_signed_o !== 1'b0) $display("FAIL mrst_signed got %b exp 0", div_signed_o); else pass_cnt++;
    total_cnt++; if (div_opdata1_o !== 32'h0) $display("FAIL mrst_opa got %h exp 0", div_opdata1_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL mrst_result got %h exp 0", result_o); else pass_cnt++;
    total_cnt++; if (div_annul_o !== 1'b0) $display("FAIL mrst_annul got %b exp 0", div_annul_o); else pass_cnt++;
    req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; req_i = 1'b0; op_i = 2'b00;
    opdata1_i = 32'h0; opdata2_i = 32'h0; div_result_i = 64'h0; div_ready_i = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_flush();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
